// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: feeds NUM_CH raw channels back to back through one streaming FFT core
// and collects each spectrum into the result RAM at {channel, bin}.
module fft_frame_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 14,
  parameter int LOG2_PTS = 10,
  parameter int RD_LAT   = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ready,
  input  logic                               raw_bank,
  input  logic                               go,
  output logic [LOG2_PTS:0]                  raw_addr,
  input  logic [NUM_CH*DATA_W-1:0]           raw_rd_data,
  output logic                               fft_sink_valid,
  output logic                               fft_sink_sop,
  output logic                               fft_sink_eop,
  output logic [DATA_W-1:0]                  fft_sink_real,
  input  logic                               fft_sink_ready,
  output logic [LOG2_PTS:0]                  fft_pts,
  input  logic                               fft_src_valid,
  input  logic                               fft_src_sop,
  input  logic                               fft_src_eop,
  input  logic [DATA_W-1:0]                  fft_src_real,
  input  logic [DATA_W-1:0]                  fft_src_imag,
  output logic                               res_wren,
  output logic [$clog2(NUM_CH)+LOG2_PTS-1:0] res_waddr,
  output logic [2*DATA_W-1:0]                res_wdata,
  output logic                               out_ready,
  output logic                               busy,
  output logic                               err
);
  localparam int PTS  = 2 ** LOG2_PTS;
  localparam int CHW  = $clog2(NUM_CH);
  localparam int CHW1 = (CHW > 0) ? CHW : 1;
  localparam int AW   = CHW + LOG2_PTS;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t state, state_n;

  logic [1:0]          ready_q, bank_q, go_q;
  logic                go_d, bank;
  logic [AW-1:0]       iss;
  logic [LOG2_PTS-1:0] idx, bin, wb;
  logic [CHW1-1:0]     ch_in;
  logic [CHW1-1:0]     pch [RD_LAT];
  logic [RD_LAT:0]     pv, ps, pe;
  logic [CHW:0]        ch_out;
  logic                go_edge, feeding, ch_done, beat, take, leave_done, sink_err, col_err;

  assign go_edge    = go_q[1] & ~go_d;
  assign feeding    = state == FEED;
  assign idx        = iss[LOG2_PTS-1:0];
  assign ch_in      = CHW1'(iss >> LOG2_PTS);
  assign raw_addr   = {bank, idx};
  assign fft_pts    = (LOG2_PTS + 1)'(PTS);
  assign busy       = state == FEED || state == DRAIN;
  assign out_ready  = state == DONE;
  assign leave_done = state == DONE && go_edge;
  assign ch_done    = ch_out == (CHW + 1)'(NUM_CH);
  assign beat       = fft_src_valid && state != IDLE;
  assign take       = beat && !ch_done;
  // a sop always restarts the spectrum at bin 0, even mid-frame
  assign wb         = fft_src_sop ? '0 : bin;
  assign sink_err   = |pv && !fft_sink_ready;
  assign col_err    = beat && (ch_done || (fft_src_sop && bin != '0) || (fft_src_eop && !(&wb)));

  // the last RD_LAT bits of each shift vector are the read-latency pipe, the top bit the output flop
  assign fft_sink_valid = pv[RD_LAT];
  assign fft_sink_sop   = ps[RD_LAT];
  assign fft_sink_eop   = pe[RD_LAT];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (ready_q[1] && fft_sink_ready) ? FEED : IDLE;
      FEED:    state_n = (&iss) ? DRAIN : FEED;
      DRAIN:   state_n = ch_done ? DONE : DRAIN;
      DONE:    state_n = go_edge ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= '0;
      bank_q  <= '0;
      go_q    <= '0;
      go_d    <= 1'b0;
      bank    <= 1'b0;
      iss     <= '0;
    end else begin
      state   <= state_n;
      ready_q <= {ready_q[0], ready};
      bank_q  <= {bank_q[0], raw_bank};
      go_q    <= {go_q[0], go};
      go_d    <= go_q[1];
      bank    <= (state == IDLE && state_n == FEED) ? bank_q[1] : bank;
      iss     <= feeding ? iss + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv            <= '0;
      ps            <= '0;
      pe            <= '0;
      fft_sink_real <= '0;
      for (int i = 0; i < RD_LAT; i++) pch[i] <= '0;
    end else begin
      pv            <= {pv[RD_LAT-1:0], feeding};
      ps            <= {ps[RD_LAT-1:0], feeding && idx == '0};
      pe            <= {pe[RD_LAT-1:0], feeding && &idx};
      fft_sink_real <= pv[RD_LAT-1] ? raw_rd_data[pch[RD_LAT-1]*DATA_W +: DATA_W] : '0;
      pch[0]        <= ch_in;
      for (int i = 1; i < RD_LAT; i++) pch[i] <= pch[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_wren  <= 1'b0;
      res_waddr <= '0;
      res_wdata <= '0;
      ch_out    <= '0;
      bin       <= '0;
      err       <= 1'b0;
    end else begin
      res_wren  <= take;
      res_waddr <= take ? AW'({ch_out, wb}) : res_waddr;
      res_wdata <= take ? {fft_src_real, fft_src_imag} : res_wdata;
      ch_out    <= leave_done ? '0 : take ? ch_out + (CHW + 1)'(fft_src_eop) : ch_out;
      bin       <= leave_done ? '0 : take ? (fft_src_eop ? '0 : wb + 1'b1) : bin;
      err       <= !leave_done && (err || sink_err || col_err);
    end
  end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: scenario table plus hand sequences around a RAM model and a fixed-latency core model.
module tb_fft_frame_ctrl;
  localparam int NC  = 4;
  localparam int DW  = 14;
  localparam int LP  = 4;
  localparam int RL  = 3;
  localparam int PTS = 16;
  localparam int NB  = NC * PTS;
  localparam int CL  = 20;
  localparam int FC  = 2 * PTS + 5;
  localparam int FE  = 3 * PTS;

  logic clk = 1'b0, rst_n = 1'b1, ready = 1'b0, raw_bank = 1'b0, go = 1'b0;
  logic fft_sink_ready = 1'b1, fault_mode = 1'b0, mon_clr = 1'b0;
  logic [LP:0] raw_addr, fft_pts;
  logic [NC*DW-1:0] raw_rd_data;
  logic fft_sink_valid, fft_sink_sop, fft_sink_eop;
  logic [DW-1:0] fft_sink_real, fft_src_real, fft_src_imag;
  logic fft_src_valid, fft_src_sop, fft_src_eop;
  logic res_wren, out_ready, busy, err;
  logic [5:0] res_waddr;
  logic [2*DW-1:0] res_wdata;

  int n_cmp = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_frame_ctrl #(.NUM_CH(NC), .DATA_W(DW), .LOG2_PTS(LP), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .raw_bank(raw_bank), .go(go),
    .raw_addr(raw_addr), .raw_rd_data(raw_rd_data),
    .fft_sink_valid(fft_sink_valid), .fft_sink_sop(fft_sink_sop), .fft_sink_eop(fft_sink_eop),
    .fft_sink_real(fft_sink_real), .fft_sink_ready(fft_sink_ready), .fft_pts(fft_pts),
    .fft_src_valid(fft_src_valid), .fft_src_sop(fft_src_sop), .fft_src_eop(fft_src_eop),
    .fft_src_real(fft_src_real), .fft_src_imag(fft_src_imag),
    .res_wren(res_wren), .res_waddr(res_waddr), .res_wdata(res_wdata),
    .out_ready(out_ready), .busy(busy), .err(err)
  );

  // raw RAM: data tagged {random, channel, address}, returned RL cycles after the address
  logic [DW-1:0] mem [NC][32];
  logic [LP:0] apipe [RL];
  always @(posedge clk) begin
    apipe[0] <= raw_addr;
    for (int i = 1; i < RL; i++) apipe[i] <= apipe[i-1];
  end
  always_comb begin
    raw_rd_data = '0;
    for (int c = 0; c < NC; c++) raw_rd_data[c*DW +: DW] = mem[c][apipe[RL-1]];
  end

  // ideal core: pure CL-cycle delay, imag = real ^ 0x2AAA, optional stray sop at channel 2 bin 5
  typedef struct packed {logic v; logic s; logic e; logic [DW-1:0] d;} beat_t;
  beat_t dl [CL];
  always @(posedge clk) begin
    dl[0] <= {fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real};
    for (int i = 1; i < CL; i++) dl[i] <= dl[i-1];
  end
  assign fft_src_valid = dl[CL-1].v;
  assign fft_src_eop   = dl[CL-1].e;
  assign fft_src_real  = dl[CL-1].d;
  assign fft_src_imag  = dl[CL-1].d ^ 14'h2AAA;
  assign fft_src_sop   = dl[CL-1].s | (fault_mode && dl[CL-1].v && dl[CL-1].d[6:5] == 2'd2 && dl[CL-1].d[3:0] == 4'd5);

  int sink_cyc[$];
  logic [DW-1:0] sink_d[$];
  logic sink_s[$], sink_e[$];
  logic [LP:0] addr_q[$];
  logic [5:0] wa_q[$];
  logic [2*DW-1:0] wd_q[$];
  logic busy_seen = 1'b0;
  int busy_cyc = 0, feed_n = 0;

  always @(negedge clk) begin
    if (mon_clr) begin
      sink_cyc.delete(); sink_d.delete(); sink_s.delete(); sink_e.delete();
      addr_q.delete(); wa_q.delete(); wd_q.delete();
      busy_seen <= 1'b0;
      feed_n    <= 0;
    end else begin
      if (busy && !busy_seen) begin
        busy_seen <= 1'b1;
        busy_cyc  <= cyc;
      end
      if ((busy || busy_seen) && feed_n < NB) begin
        addr_q.push_back(raw_addr);
        feed_n <= feed_n + 1;
      end
      if (fft_sink_valid) begin
        sink_cyc.push_back(cyc); sink_d.push_back(fft_sink_real);
        sink_s.push_back(fft_sink_sop); sink_e.push_back(fft_sink_eop);
      end
      if (res_wren) begin
        wa_q.push_back(res_waddr); wd_q.push_back(res_wdata);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_d(input logic b, input int n);
    return (n < NB) ? mem[n / PTS][b * PTS + n % PTS] : '0;
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_raw_addr"}, raw_addr, 0);
    chk({tag, "_sink"}, {fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real}, 0);
    chk({tag, "_res"}, {res_wren, res_waddr, res_wdata}, 0);
    chk({tag, "_status"}, {out_ready, busy, err}, 0);
  endtask

  typedef struct {logic bank; logic fault; logic drop; logic go_feed; logic exp_err;} scen_t;
  scen_t tbl [4];

  task automatic run_scen(input scen_t s);
    int rc, ea;
    logic [DW-1:0] d;
    raw_bank   = s.bank;
    fault_mode = s.fault;
    tick(3);
    clr_mon();
    tick(1);
    ready = 1'b1;
    rc = cyc;
    for (int i = 0; i < 20 && !busy_seen; i++) tick(1);
    chk("busy_seen", busy_seen, 1);
    chk("ready_to_feed_lat", busy_cyc - rc, 3);
    ready = 1'b0;
    if (s.go_feed) begin
      tick($urandom_range(3, 30));
      go = 1'b1; tick(3); go = 1'b0;
    end
    if (s.drop) begin
      tick($urandom_range(5, 40));
      fft_sink_ready = 1'b0; tick(1); fft_sink_ready = 1'b1;
    end
    for (int i = 0; i < 400 && !out_ready; i++) tick(1);
    chk("out_ready", out_ready, 1);
    chk("n_raw", addr_q.size(), NB);
    foreach (addr_q[i]) chk("raw_addr", addr_q[i], {s.bank, 4'(i % PTS)});
    chk("n_sink", sink_d.size(), NB);
    if (sink_cyc.size() > 0) chk("first_sop_lat", sink_cyc[0] - busy_cyc, RL + 1);
    foreach (sink_d[n])
      chk("sink_beat", {sink_cyc[n] - sink_cyc[0], sink_d[n], sink_s[n], sink_e[n]},
          {n, exp_d(s.bank, n), n % PTS == 0, n % PTS == PTS - 1});
    chk("n_wr", wa_q.size(), NB);
    foreach (wa_q[n]) begin
      ea = (s.fault && n >= FC && n < FE) ? 2 * PTS + n - FC : n;
      d = exp_d(s.bank, n);
      chk("wr_addr", wa_q[n], ea);
      chk("wr_data", wd_q[n], {d, d ^ 14'h2AAA});
    end
    chk("err_sticky", err, s.exp_err);
    go = 1'b1;
    repeat (3) @(negedge clk);
    chk("out_ready_hold", out_ready, 1);
    @(negedge clk);
    chk("out_ready_drop", {out_ready, busy, err}, 0);
    tick(1);
    go = 1'b0;
    tick(3);
  endtask

  initial begin
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < 32; a++) mem[c][a] = {7'($urandom), 2'(c), 5'(a)};
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    #1 rst_n = 1'b0;
    tick(3);
    reset_checks("rst");
    chk("fft_pts", fft_pts, PTS);
    rst_n = 1'b1;
    tick(3);
    reset_checks("post_rst");
    fft_sink_ready = 1'b0;
    ready = 1'b1;
    tick(10);
    chk("idle_sink_not_ready", {busy, err}, 0);
    ready = 1'b0;
    tick(4);
    fft_sink_ready = 1'b1;
    tick(3);
    chk("idle_stays", busy, 0);
    for (int t = 0; t < 4; t++) run_scen(tbl[t]);
    raw_bank = 1'b1;
    fault_mode = 1'b0;
    tick(3);
    clr_mon();
    tick(1);
    ready = 1'b1;
    for (int i = 0; i < 20 && !busy_seen; i++) tick(1);
    for (int i = 0; i < 400 && !out_ready; i++) tick(1);
    chk("hold_done", out_ready, 1);
    raw_bank = 1'b0;
    tick(3);
    clr_mon();
    tick(1);
    go = 1'b1; tick(3); go = 1'b0;
    for (int i = 0; i < 30 && !busy_seen; i++) tick(1);
    chk("restart_with_ready_held", busy_seen, 1);
    tick(1);
    chk("rebank_n", addr_q.size() > 0, 1);
    if (addr_q.size() > 0) chk("rebank_addr", addr_q[0], 0);
    tick(20);
    chk("busy_pre_rst", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {raw_addr, fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real,
                           res_wren, res_waddr, res_wdata, out_ready, busy, err}, 0);
    ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    clr_mon();
    tick(60);
    chk("no_wr_after_rst", wa_q.size(), 0);
    chk("idle_after_rst", {out_ready, busy, err}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
